dmem_sram_like_slave: RTL and testbench

Data-side memory responder for the myCPU sram-like data interface. It receives the byte-enable, size, address and lane-replicated write data that the load/store unit produces after alignment checks, and performs word-wide byte-masked writes into an internal RAM. It returns full 32-bit read words after a programmable latency through an addr_ok/data_ok handshake. It serves as the simulation and FPGA data memory behind the MEM stage, and it independently flags requests whose strobe/size/address combination is illegal.

---
 rtl/dmem_sram_like_slave_if.sv | 23 ++
 rtl/dmem_sram_like_slave.sv | 114 +++++++++++
 tb/tb_dmem_sram_like_slave.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_sram_like_slave_if.sv
// Sram-like data bus between the CPU load/store unit and its data memory.
interface dmem_sram_like_slave_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, wr, size, addr, wstrb, wdata,
        input  addr_ok, data_ok, rdata, err
    );

    modport slave (
        input  req, wr, size, addr, wstrb, wdata,
        output addr_ok, data_ok, rdata, err
    );
endinterface

// File: rtl/dmem_sram_like_slave.sv
// Data memory responder: byte-masked word writes, full-word reads returned
// after a fixed latency, with illegal strobe/size/address combinations flagged.
module dmem_sram_like_slave #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned LATENCY    = 2
) (
    input logic                   clk,
    input logic                   rst,
    dmem_sram_like_slave_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    localparam int unsigned Depth   = 1 << ADDR_WIDTH;
    // BUSY counts down to zero, then one more edge to reach RESP.
    localparam logic [3:0]  CntInit = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    logic [31:0] mem [Depth];

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic                  addr_ok;
    logic                  accept;
    logic                  legal;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  unused_addr_hi;

    assign word_idx       = bus.addr[ADDR_WIDTH+1:2];
    // Address bits above the word index alias onto the same RAM word.
    assign unused_addr_hi = ^bus.addr[31:ADDR_WIDTH+2];

    assign addr_ok = !rst && ((state_q == StIdle) || (state_q == StResp));
    assign accept  = bus.req && addr_ok;

    assign bus.addr_ok = addr_ok;
    assign bus.data_ok = !rst && (state_q == StResp);
    assign bus.rdata   = rdata_q;
    assign bus.err     = err_q;

    // Legality of the presented request: alignment per size, exact strobe for stores.
    always_comb begin
        legal = 1'b0;
        case (bus.size)
            2'b00: legal = !bus.wr || (bus.wstrb == (4'b0001 << bus.addr[1:0]));
            2'b01: legal = !bus.addr[0] &&
                           (!bus.wr || (bus.wstrb == (bus.addr[1] ? 4'b1100 : 4'b0011)));
            2'b10: legal = (bus.addr[1:0] == 2'b00) && (!bus.wr || (bus.wstrb == 4'b1111));
            default: legal = 1'b0;
        endcase
    end

    // Next-state: latency countdown, response cycle, and accept in IDLE or RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StBusy: begin
                if (cnt_q == 4'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (!accept) begin
                    state_d = StIdle;
                    rdata_d = '0;
                    err_d   = 1'b0;
                end
            end
            default: ;
        endcase
        if (accept) begin
            rdata_d = (legal && !bus.wr) ? mem[word_idx] : '0;
            err_d   = !legal;
            if (LATENCY == 1) begin
                state_d = StResp;
            end else begin
                cnt_d   = CntInit;
                state_d = StBusy;
            end
        end
    end

    // Control and response registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // RAM write at the accept edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && legal && bus.wr) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem[word_idx][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_dmem_sram_like_slave.sv
// Bench for dmem_sram_like_slave: three instances (latency 1, 2, 4) checked
// against a word-array reference model, directed cases plus random traffic.
module tb_dmem_sram_like_slave;
    localparam int AW = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned lat_c [3] = '{1, 2, 4};

    logic [2:0]  rst_a;
    logic [2:0]  req_a;
    logic [2:0]  wr_a;
    logic [1:0]  size_a  [3];
    logic [31:0] addr_a  [3];
    logic [3:0]  wstrb_a [3];
    logic [31:0] wdata_a [3];
    wire  [2:0]  aok_a;
    wire  [2:0]  dok_a;
    wire  [2:0]  err_a;
    wire  [31:0] rdata_a [3];

    bit [31:0] mm [3][1 << AW];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned L = (g == 0) ? 1 : (g == 1) ? 2 : 4;
        dmem_sram_like_slave_if bus ();
        assign bus.req    = req_a[g];
        assign bus.wr     = wr_a[g];
        assign bus.size   = size_a[g];
        assign bus.addr   = addr_a[g];
        assign bus.wstrb  = wstrb_a[g];
        assign bus.wdata  = wdata_a[g];
        assign aok_a[g]   = bus.addr_ok;
        assign dok_a[g]   = bus.data_ok;
        assign err_a[g]   = bus.err;
        assign rdata_a[g] = bus.rdata;
        dmem_sram_like_slave #(.ADDR_WIDTH(AW), .LATENCY(L)) u_dut (
            .clk (clk),
            .rst (rst_a[g]),
            .bus (bus)
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Access of 2^size bytes must be size-aligned; a store must strobe exactly those bytes.
    function automatic bit is_legal(bit w, logic [1:0] sz, logic [31:0] a, logic [3:0] st);
        int nbytes;
        logic [3:0] need;
        if (sz == 2'b11) return 1'b0;
        nbytes = 1 << sz;
        if ((int'(a[1:0]) % nbytes) != 0) return 1'b0;
        need = 4'(((1 << nbytes) - 1) << a[1:0]);
        return !w || (st == need);
    endfunction

    task automatic drive(input int k, input bit w, input logic [1:0] sz, input logic [31:0] a,
                         input logic [3:0] st, input logic [31:0] wd);
        wr_a[k] = w; size_a[k] = sz; addr_a[k] = a; wstrb_a[k] = st; wdata_a[k] = wd;
        req_a[k] = 1'b1;
    endtask

    // Apply the request to the model; returns the read word the DUT should report.
    function automatic logic [31:0] model_accept(int k, bit w, logic [1:0] sz, logic [31:0] a,
                                                 logic [3:0] st, logic [31:0] wd);
        int idx = int'(a[AW+1:2]);
        bit lg  = is_legal(w, sz, a, st);
        if (lg && w)
            for (int i = 0; i < 4; i++) if (st[i]) mm[k][idx][8*i +: 8] = wd[8*i +: 8];
        return (lg && !w) ? mm[k][idx] : 32'h0;
    endfunction

    // One complete transaction, called with time just after a rising edge.
    task automatic txn(input string t, input int k, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [3:0] st, input logic [31:0] wd,
                       output logic [31:0] got);
        int n = 0;
        logic [31:0] exp;
        bit lg;
        drive(k, w, sz, a, st, wd);
        while (!aok_a[k] && n < 40) begin @(posedge clk); #1; n++; end
        if (!aok_a[k]) begin
            check_eq({t, "/addr_ok_timeout"}, 32'(aok_a[k]), 32'd1);
            req_a[k] = 1'b0;
            got = '0;
            return;
        end
        lg  = is_legal(w, sz, a, st);
        exp = model_accept(k, w, sz, a, st, wd);
        @(posedge clk); #1;
        req_a[k] = 1'b0;
        n = 1;
        while (!dok_a[k] && n < 40) begin @(posedge clk); #1; n++; end
        check_eq({t, "/latency"}, 32'(n), 32'(lat_c[k]));
        check_eq({t, "/err"}, 32'(err_a[k]), 32'(!lg));
        check_eq({t, "/rdata"}, rdata_a[k], exp);
        got = rdata_a[k];
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] got;
        logic [31:0] bb_exp [4];
        int n;

        rst_a = '1; req_a = '0; wr_a = '0;
        for (int k = 0; k < 3; k++) begin
            size_a[k] = 2'b10; addr_a[k] = '0; wstrb_a[k] = '0; wdata_a[k] = '0;
        end

        // Reset: addr_ok low while rst high, idle outputs after release.
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) check_eq("rst/addr_ok_in_reset", 32'(aok_a[k]), 32'd0);
        rst_a = '0;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            check_eq("rst/addr_ok", 32'(aok_a[k]), 32'd1);
            check_eq("rst/data_ok", 32'(dok_a[k]), 32'd0);
            check_eq("rst/rdata", rdata_a[k], 32'd0);
            check_eq("rst/err", 32'(err_a[k]), 32'd0);
        end

        // Word store/load, byte-lane merge, illegal requests (latency 2).
        txn("word_st", 1, 1, 2'b10, 32'h10, 4'hF, 32'hDEADBEEF, got);
        txn("word_ld", 1, 0, 2'b10, 32'h10, 4'h0, 32'h0, got);
        check_eq("word_ld/const", got, 32'hDEADBEEF);
        txn("byte_st", 1, 1, 2'b00, 32'h13, 4'b1000, 32'h5A5A5A5A, got);
        txn("half_st", 1, 1, 2'b01, 32'h10, 4'b0011, 32'h12341234, got);
        txn("merge_ld", 1, 0, 2'b10, 32'h10, 4'h0, 32'h0, got);
        check_eq("merge_ld/const", got, 32'h5AAD1234);
        txn("ill_word_st", 1, 1, 2'b10, 32'h12, 4'hF, 32'hFFFFFFFF, got);
        txn("ill_half_ld", 1, 0, 2'b01, 32'h11, 4'h0, 32'h0, got);
        txn("ill_size3", 1, 0, 2'b11, 32'h10, 4'h0, 32'h0, got);
        txn("ill_byte_st", 1, 1, 2'b00, 32'h11, 4'b0001, 32'h77777777, got);
        txn("ill_check_ld", 1, 0, 2'b10, 32'h10, 4'h0, 32'h0, got);
        check_eq("ill_check_ld/const", got, 32'h5AAD1234);

        // Back-to-back on latency 1: req held through alternating store/load.
        bb_exp = '{32'h0, 32'h11223344, 32'h0, 32'h55667788};
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive(0, 1, 2'b10, 32'h20, 4'hF, (i == 0) ? 32'h11223344 : 32'h55667788);
            else            drive(0, 0, 2'b10, 32'h20, 4'h0, 32'h0);
            check_eq("b2b/addr_ok", 32'(aok_a[0]), 32'd1);
            void'(model_accept(0, wr_a[0], size_a[0], addr_a[0], wstrb_a[0], wdata_a[0]));
            @(posedge clk); #1;
            check_eq("b2b/data_ok", 32'(dok_a[0]), 32'd1);
            check_eq("b2b/rdata", rdata_a[0], bb_exp[i]);
        end
        req_a[0] = 1'b0;
        @(posedge clk); #1;
        check_eq("b2b/data_ok_end", 32'(dok_a[0]), 32'd0);

        // Busy backpressure on latency 4.
        drive(2, 1, 2'b10, 32'h30, 4'hF, 32'hA5A5F00F);
        check_eq("bp/addr_ok_first", 32'(aok_a[2]), 32'd1);
        void'(model_accept(2, 1, 2'b10, 32'h30, 4'hF, 32'hA5A5F00F));
        @(posedge clk); #1;
        drive(2, 0, 2'b10, 32'h30, 4'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check_eq("bp/addr_ok_busy", 32'(aok_a[2]), 32'd0);
            check_eq("bp/data_ok_busy", 32'(dok_a[2]), 32'd0);
            @(posedge clk); #1;
        end
        check_eq("bp/data_ok_first", 32'(dok_a[2]), 32'd1);
        check_eq("bp/addr_ok_resp", 32'(aok_a[2]), 32'd1);
        @(posedge clk); #1;
        req_a[2] = 1'b0;
        n = 1;
        while (!dok_a[2] && n < 40) begin @(posedge clk); #1; n++; end
        check_eq("bp/latency_second", 32'(n), 32'd4);
        check_eq("bp/rdata_second", rdata_a[2], 32'hA5A5F00F);

        // Reset two cycles after a store accept; a store presented with rst is dropped.
        @(posedge clk); #1;
        drive(2, 1, 2'b10, 32'h40, 4'hF, 32'hCAFEF00D);
        void'(model_accept(2, 1, 2'b10, 32'h40, 4'hF, 32'hCAFEF00D));
        @(posedge clk); #1;
        req_a[2] = 1'b0;
        @(posedge clk); #1;
        rst_a[2] = 1'b1;
        drive(2, 1, 2'b10, 32'h40, 4'hF, 32'h0BADBAD0);
        check_eq("rstmid/addr_ok_rst", 32'(aok_a[2]), 32'd0);
        @(posedge clk); #1;
        check_eq("rstmid/data_ok", 32'(dok_a[2]), 32'd0);
        check_eq("rstmid/rdata", rdata_a[2], 32'd0);
        check_eq("rstmid/err", 32'(err_a[2]), 32'd0);
        req_a[2] = 1'b0;
        rst_a[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_eq("rstmid/no_pulse", 32'(dok_a[2]), 32'd0);
        end
        txn("rstmid_ld", 2, 0, 2'b10, 32'h40, 4'h0, 32'h0, got);
        check_eq("rstmid_ld/const", got, 32'hCAFEF00D);

        // Random traffic over a pre-initialised 64-word window with aliased high bits.
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 64; w++) txn("init", k, 1, 2'b10, 32'(w * 4), 4'hF, $urandom(), got);
            for (int i = 0; i < 150; i++) begin
                logic [31:0] r, a;
                logic [1:0]  sz;
                logic [3:0]  st;
                int          off;
                r   = $urandom();
                sz  = 2'($urandom_range(0, 3));
                off = $urandom_range(0, 255);
                if (sz != 2'b11 && $urandom_range(0, 3) != 0) off = off & ~((1 << sz) - 1);
                a   = {r[31:14], 6'b0, 8'(off)};
                st  = ($urandom_range(0, 3) != 0) ? 4'(((1 << (1 << sz)) - 1) << a[1:0])
                                                  : 4'($urandom());
                txn("rand", k, 1'($urandom()), sz, a, st, $urandom(), got);
                if ($urandom_range(0, 4) == 0) begin @(posedge clk); #1; end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
